// File: rtl/ecdsa_stream_pkg.sv
// Shared types and helpers for the ECDSA stream front end.
package ecdsa_stream_pkg;

    localparam int DEFAULT_DATA_W = 256;

    typedef enum logic [1:0] {GATHER, START, WAIT, DRAIN} state_t;

    // Beat counter width; a single-beat stream still gets a 1-bit counter.
    function automatic int cnt_w(input int beats);
        return $clog2(beats < 2 ? 2 : beats);
    endfunction

endpackage

// File: rtl/ecdsa_stream_accel_packer.sv
// stream_beat_packer: collects IN_BEATS input beats into one message word.
// Framing check on tlast is compiled in only with FRAME_CHECK_EN.
module stream_beat_packer
    import ecdsa_stream_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int IN_BEATS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_accept,
    input  logic [DATA_W-1:0]          i_tdata,
    input  logic                       i_tlast,
    output logic [DATA_W*IN_BEATS-1:0] o_msg,
    output logic                       o_msg_done,
    output logic                       o_frame_err
);
    localparam int             CW   = cnt_w(IN_BEATS);
    localparam logic [CW-1:0]  LAST = CW'(IN_BEATS - 1);

    logic [CW-1:0]              r_in_cnt;
    logic [DATA_W*IN_BEATS-1:0] r_msg;
    logic                       r_frame_err;
    logic                       w_last_beat;
    logic                       w_early;
    logic                       w_late;

    assign w_last_beat = (r_in_cnt == LAST);

`ifdef FRAME_CHECK_EN
    assign w_early = i_accept & i_tlast & ~w_last_beat;
    assign w_late  = i_accept & ~i_tlast & w_last_beat;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = i_tlast;
    assign w_early        = 1'b0;
    assign w_late         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt    <= '0;
            r_msg       <= '0;
            r_frame_err <= 1'b0;
        end else if (i_accept) begin
            if (w_early) begin
                // Early tlast: drop the partial message and restart at beat 0.
                r_in_cnt    <= '0;
                r_frame_err <= 1'b1;
            end else begin
                for (int b = 0; b < IN_BEATS; b++)
                    if (r_in_cnt == CW'(b))
                        r_msg[b*DATA_W +: DATA_W] <= i_tdata;
                r_in_cnt <= w_last_beat ? '0 : r_in_cnt + 1'b1;
                if (w_late)
                    r_frame_err <= 1'b1;
            end
        end
    end

    assign o_msg       = r_msg;
    assign o_msg_done  = i_accept & w_last_beat;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ecdsa_stream_accel.sv
// AXI-Stream wrapper around a start/busy/done crypto core: gather, launch, capture, serialise.
// Optional tlast framing check enabled by defining FRAME_CHECK_EN.
module ecdsa_stream_accel
    import ecdsa_stream_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int IN_BEATS  = 2,
    parameter int OUT_BEATS = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           ina_tdata,
    input  logic                        ina_tvalid,
    input  logic                        ina_tlast,
    output logic                        ina_tready,
    output logic [DATA_W-1:0]           outa_tdata,
    output logic                        outa_tvalid,
    output logic                        outa_tlast,
    input  logic                        outa_tready,
    output logic                        core_start,
    output logic [DATA_W*IN_BEATS-1:0]  core_msg,
    input  logic                        core_busy,
    input  logic                        core_done,
    input  logic [DATA_W*OUT_BEATS-1:0] core_result,
    output logic                        frame_err
);
    localparam int            OCW   = cnt_w(OUT_BEATS);
    localparam logic [OCW-1:0] OLAST = OCW'(OUT_BEATS - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_ina_tready;
    logic [OCW-1:0]              r_out_cnt;
    logic [DATA_W*OUT_BEATS-1:0] r_res;
    logic                        w_accept;
    logic                        w_msg_done;
    logic                        w_out_last;

    assign w_accept   = ina_tvalid & r_ina_tready;
    assign w_out_last = (r_out_cnt == OLAST);

    stream_beat_packer #(
        .DATA_W   (DATA_W),
        .IN_BEATS (IN_BEATS)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_accept    (w_accept),
        .i_tdata     (ina_tdata),
        .i_tlast     (ina_tlast),
        .o_msg       (core_msg),
        .o_msg_done  (w_msg_done),
        .o_frame_err (frame_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        core_start  = 1'b0;
        case (r_state)
            GATHER: if (w_msg_done) w_state_nxt = START;
            START: if (!core_busy) begin
                core_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT:   if (core_done) w_state_nxt = DRAIN;
            DRAIN:  if (outa_tready && w_out_last) w_state_nxt = GATHER;
            default: w_state_nxt = GATHER;
        endcase
    end

    // tready follows the next state so it is a clean register output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= GATHER;
            r_ina_tready <= 1'b0;
            r_out_cnt    <= '0;
            r_res        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ina_tready <= (w_state_nxt == GATHER);
            if (r_state == WAIT && core_done)
                r_res <= core_result;
            if (r_state == DRAIN && outa_tready)
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
        end
    end

    always_comb begin
        outa_tdata = '0;
        if (r_state == DRAIN)
            for (int b = 0; b < OUT_BEATS; b++)
                if (r_out_cnt == OCW'(b))
                    outa_tdata = r_res[b*DATA_W +: DATA_W];
    end

    assign ina_tready  = r_ina_tready;
    assign outa_tvalid = (r_state == DRAIN);
    assign outa_tlast  = (r_state == DRAIN) && w_out_last;

endmodule

// File: tb/tb_ecdsa_stream_accel.sv
// Directed bench: two instances (OUT_BEATS=1 and 2) share the same stimulus.
module tb_ecdsa_stream_accel;
    localparam int DW = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   ina_tdata;
    logic            ina_tvalid, ina_tlast, outa_tready;
    logic            core_busy, core_done;
    logic [2*DW-1:0] core_result;

    logic            rdy1, vld1, last1, start1, ferr1;
    logic            rdy2, vld2, last2, start2, ferr2;
    logic [DW-1:0]   data1, data2;
    logic [2*DW-1:0] msg1, msg2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ecdsa_stream_accel #(.DATA_W(DW), .IN_BEATS(2), .OUT_BEATS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ina_tdata(ina_tdata), .ina_tvalid(ina_tvalid), .ina_tlast(ina_tlast), .ina_tready(rdy1),
        .outa_tdata(data1), .outa_tvalid(vld1), .outa_tlast(last1), .outa_tready(outa_tready),
        .core_start(start1), .core_msg(msg1), .core_busy(core_busy), .core_done(core_done),
        .core_result(core_result[DW-1:0]), .frame_err(ferr1)
    );

    ecdsa_stream_accel #(.DATA_W(DW), .IN_BEATS(2), .OUT_BEATS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .ina_tdata(ina_tdata), .ina_tvalid(ina_tvalid), .ina_tlast(ina_tlast), .ina_tready(rdy2),
        .outa_tdata(data2), .outa_tvalid(vld2), .outa_tlast(last2), .outa_tready(outa_tready),
        .core_start(start2), .core_msg(msg2), .core_busy(core_busy), .core_done(core_done),
        .core_result(core_result), .frame_err(ferr2)
    );

    task automatic chk(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rdy1 && rdy2) && n < 20) begin
            tick();
            n++;
        end
        if (!(rdy1 && rdy2)) chk("ready_timeout", 0, 1);
    endtask

    // Sends two beats; returns at the negedge right after the last handshake.
    task automatic send2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        wait_ready();
        ina_tdata = a; ina_tvalid = 1'b1; ina_tlast = 1'b0;
        tick();
        ina_tdata = b; ina_tlast = 1'b1;
        tick();
        ina_tvalid = 1'b0; ina_tlast = 1'b0;
    endtask

    task automatic done_pulse(input logic [2*DW-1:0] res);
        core_result = res; core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    logic [DW-1:0] A, B, R, R0, R1;

    initial begin
        A  = {8{32'hAAAA_0001}};
        B  = {8{32'hBBBB_0002}};
        R  = {8{32'h1234_5678}};
        R0 = {8{32'h0000_00F0}};
        R1 = {8{32'h0000_00F1}};
        rst_n = 1'b0; ina_tdata = '0; ina_tvalid = 1'b0; ina_tlast = 1'b0;
        outa_tready = 1'b1; core_busy = 1'b0; core_done = 1'b0; core_result = '0;

        // Reset state
        tick();
        chk("rst_tready", rdy1, 0);
        chk("rst_tvalid", vld1, 0);
        chk("rst_tlast", last1, 0);
        chk("rst_tdata", data1, 0);
        chk("rst_start", start1, 0);
        chk("rst_ferr", ferr1, 0);
        rst_n = 1'b1;
        tick();
        chk("tready_after_rst", rdy1, 1);

        // 1: basic message, start one cycle after last beat, result 5 cycles later
        send2(A, B);
        chk("t1_start", start1, 1);
        chk("t1_msg", msg1, {B, A});
        tick();
        chk("t1_start_off", start1, 0);
        chk("t1_tready_low", rdy1, 0);
        repeat (4) tick();
        done_pulse({{DW{1'b0}}, R});
        chk("t1_tvalid", vld1, 1);
        chk("t1_tdata", data1, R);
        chk("t1_tlast", last1, 1);
        tick();
        chk("t1_drained", vld1, 0);

        // 2: two-beat result under backpressure
        send2(B, A);
        chk("t2_msg", msg2, {A, B});
        tick();
        outa_tready = 1'b0;
        done_pulse({R1, R0});
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_vld", vld2, 1);
            chk("t2_hold_data", data2, R0);
            chk("t2_hold_last", last2, 0);
            tick();
        end
        outa_tready = 1'b1;
        chk("t2_beat0", data2, R0);
        tick();
        chk("t2_beat1", data2, R1);
        chk("t2_beat1_last", last2, 1);
        tick();
        chk("t2_drained", vld2, 0);

        // 3: core busy delays launch
        core_busy = 1'b1;
        send2(A, A);
        for (int i = 0; i < 3; i++) begin
            chk("t3_busy_nostart", start1, 0);
            tick();
        end
        core_busy = 1'b0;
        #1 chk("t3_start", start1, 1);
        tick();
        chk("t3_single_pulse", start1, 0);
        done_pulse({{DW{1'b0}}, B});
        chk("t3_tdata", data1, B);
        tick();

        // 4: framing
        wait_ready();
`ifdef FRAME_CHECK_EN
        ina_tdata = R; ina_tvalid = 1'b1; ina_tlast = 1'b1;
        tick();
        ina_tvalid = 1'b0; ina_tlast = 1'b0;
        chk("t4_ferr", ferr1, 1);
        chk("t4_nostart", start1, 0);
        tick();
        chk("t4_nostart2", start1, 0);
        send2(B, R);
        chk("t4_clean_start", start1, 1);
        chk("t4_clean_msg", msg1, {R, B});
        chk("t4_ferr_sticky", ferr1, 1);
`else
        ina_tdata = R; ina_tvalid = 1'b1; ina_tlast = 1'b1;
        tick();
        ina_tdata = B;
        tick();
        ina_tvalid = 1'b0; ina_tlast = 1'b0;
        chk("t4_start_notlast", start1, 1);
        chk("t4_msg_notlast", msg1, {B, R});
        chk("t4_ferr_tied", ferr1, 0);
`endif
        tick();
        done_pulse({{DW{1'b0}}, A});
        chk("t4_tdata", data1, A);
        tick();

        // 5: reset during WAIT
        send2(R, R);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_tready", rdy1, 0);
        chk("t5_start", start1, 0);
        chk("t5_tvalid", vld1, 0);
        chk("t5_tdata", data1, 0);
        chk("t5_ferr", ferr1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_tready_rel", rdy1, 1);
        send2(A, B);
        chk("t5_msg", msg1, {B, A});
        tick();
        done_pulse({{DW{1'b0}}, R1});
        chk("t5_tdata", data1, R1);
        tick();

        // 6: spurious done in GATHER
        wait_ready();
        done_pulse({R, R});
        chk("t6_no_valid", vld1, 0);
        chk("t6_still_ready", rdy1, 1);
        tick();
        chk("t6_no_valid2", vld1, 0);
        send2(R0, R1);
        chk("t6_start", start1, 1);
        tick();
        done_pulse({{DW{1'b0}}, R0});
        chk("t6_tdata", data1, R0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
